ras_predecode_redirect: RTL and testbench

- Fetch-stage consumer of the branch pre-decode outputs (is_call, is_ret, cfi_type, target).
- Maintains a circular return-address stack (RAS) and produces a registered redirect target for the frontend.
- Backend repair on mispredict is done by restoring the stack pointer and count from a checkpoint.
- Sits between the pre-decode stage and the fetch-target queue / next-PC mux.

---
 rtl/ras_pkg.sv | 9 +
 rtl/ras_storage.sv | 17 +
 rtl/ras_predecode_redirect.sv | 99 +++++++++
 tb/tb_ras_predecode_redirect.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// ras_pkg: shared types and constants for the return-address-stack predictor
package ras_pkg;
  typedef enum logic [2:0] {CFI_NONE = 3'd0, CFI_BR = 3'd1, CFI_JAL = 3'd2, CFI_JALR = 3'd3} cfi_type_e;
  localparam int RAS_DEPTH = 32;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = RAS_PTR_W + 1;
  localparam int RVC_INC = 2;
  localparam int RVI_INC = 4;
endpackage

// File: rtl/ras_storage.sv
// ras_storage: DEPTH x VADDR_W register array, one write port, one async read port
module ras_storage #(
  parameter int DEPTH = 32,
  parameter int VADDR_W = 40
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [VADDR_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [VADDR_W-1:0]       rdata
);
  logic [VADDR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/ras_predecode_redirect.sv
// ras_predecode_redirect: RAS push/pop on pre-decoded CFIs with registered redirect; RAS_PERF_CNT_EN adds over/underflow counters
module ras_predecode_redirect
  import ras_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int VADDR_W = 40
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [VADDR_W-1:0]       io_in_pc,
  input  logic                     io_in_rvc,
  input  logic                     io_in_is_call,
  input  logic                     io_in_is_ret,
  input  logic [2:0]               io_in_cfi_type,
  input  logic [VADDR_W-1:0]       io_in_target,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic                     io_out_redirect,
  output logic [VADDR_W-1:0]       io_out_target,
  output logic [2:0]               io_out_cfi_type,
  output logic [$clog2(DEPTH)-1:0] io_out_ptr,
  output logic [$clog2(DEPTH):0]   io_out_count,
`ifdef RAS_PERF_CNT_EN
  output logic [15:0]              io_perf_overflow,
  output logic [15:0]              io_perf_underflow,
`endif
  input  logic                     io_flush,
  input  logic                     io_restore_valid,
  input  logic [$clog2(DEPTH)-1:0] io_restore_ptr,
  input  logic [$clog2(DEPTH):0]   io_restore_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [PW-1:0] ptr, ptr_dec, waddr;
  logic [CW-1:0] count;
  logic [VADDR_W-1:0] ret_addr, top;
  logic accept, empty, full, swap, push, pop;
  assign io_in_ready = ~io_restore_valid & (~io_out_valid | io_out_ready);
  assign accept = io_in_valid & io_in_ready;
  assign empty = count == '0;
  assign full = count == FULL;
  assign ptr_dec = ptr - PW'(1);
  assign ret_addr = io_in_pc + (io_in_rvc ? VADDR_W'(RVC_INC) : VADDR_W'(RVI_INC));
  // call+ret on an empty stack degenerates to a plain call
  assign swap = io_in_is_call & io_in_is_ret & ~empty;
  assign push = io_in_is_call & ~swap;
  assign pop = io_in_is_ret & ~io_in_is_call & ~empty;
  assign waddr = swap ? ptr_dec : ptr;
  ras_storage #(.DEPTH(DEPTH), .VADDR_W(VADDR_W)) u_storage (
    .clk(clock), .we(accept & io_in_is_call), .waddr(waddr), .wdata(ret_addr),
    .raddr(ptr_dec), .rdata(top)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      count <= '0;
      io_out_valid <= 1'b0;
      io_out_redirect <= 1'b0;
      io_out_target <= '0;
      io_out_cfi_type <= '0;
      io_out_ptr <= '0;
      io_out_count <= '0;
    end else if (io_restore_valid) begin
      ptr <= io_restore_ptr;
      count <= io_restore_count > FULL ? FULL : io_restore_count;
      io_out_valid <= 1'b0;
    end else if (accept) begin
      io_out_valid <= 1'b1;
      io_out_redirect <= io_in_is_ret ? ~empty : io_in_cfi_type == CFI_JAL;
      io_out_target <= io_in_is_ret ? (empty ? '0 : top) : io_in_target;
      io_out_cfi_type <= io_in_cfi_type;
      io_out_ptr <= ptr;
      io_out_count <= count;
      if (push) begin
        ptr <= ptr + PW'(1);
        count <= full ? count : count + CW'(1);
      end else if (pop) begin
        ptr <= ptr_dec;
        count <= count - CW'(1);
      end
    end else if (io_flush | io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end
`ifdef RAS_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_overflow <= '0;
      io_perf_underflow <= '0;
    end else if (accept & ~io_restore_valid) begin
      if (push & full & io_perf_overflow != '1) io_perf_overflow <= io_perf_overflow + 16'd1;
      if (io_in_is_ret & ~io_in_is_call & empty & io_perf_underflow != '1) io_perf_underflow <= io_perf_underflow + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ras_predecode_redirect.sv
// tb_ras_predecode_redirect: directed vectors for the RAS redirect stage (DEPTH=32, VADDR_W=40)
module tb_ras_predecode_redirect;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic io_in_valid = 1'b0, io_in_ready, io_in_rvc = 1'b0, io_in_is_call = 1'b0, io_in_is_ret = 1'b0;
  logic [39:0] io_in_pc = '0, io_in_target = '0, io_out_target;
  logic [2:0] io_in_cfi_type = '0, io_out_cfi_type;
  logic io_out_valid, io_out_ready = 1'b1, io_out_redirect, io_flush = 1'b0, io_restore_valid = 1'b0;
  logic [4:0] io_out_ptr, io_restore_ptr = '0;
  logic [5:0] io_out_count, io_restore_count = '0;
`ifdef RAS_PERF_CNT_EN
  logic [15:0] io_perf_overflow, io_perf_underflow;
`endif
  int pass = 0, total = 0;

  ras_predecode_redirect #(.DEPTH(32), .VADDR_W(40)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_pc(io_in_pc), .io_in_rvc(io_in_rvc),
    .io_in_is_call(io_in_is_call), .io_in_is_ret(io_in_is_ret), .io_in_cfi_type(io_in_cfi_type),
    .io_in_target(io_in_target), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_redirect(io_out_redirect), .io_out_target(io_out_target), .io_out_cfi_type(io_out_cfi_type),
    .io_out_ptr(io_out_ptr), .io_out_count(io_out_count),
`ifdef RAS_PERF_CNT_EN
    .io_perf_overflow(io_perf_overflow), .io_perf_underflow(io_perf_underflow),
`endif
    .io_flush(io_flush), .io_restore_valid(io_restore_valid),
    .io_restore_ptr(io_restore_ptr), .io_restore_count(io_restore_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic rst_dut();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [39:0] pc, input logic rvc, input logic call, input logic ret,
                      input logic [2:0] cfi, input logic [39:0] tgt);
    io_in_pc = pc; io_in_rvc = rvc; io_in_is_call = call; io_in_is_ret = ret;
    io_in_cfi_type = cfi; io_in_target = tgt; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  initial begin
    rst_dut();
    check("rst_valid", io_out_valid, 0);
    check("rst_redirect", io_out_redirect, 0);
    check("rst_target", io_out_target, 0);
    check("rst_cfi", io_out_cfi_type, 0);
    check("rst_ptr", io_out_ptr, 0);
    check("rst_count", io_out_count, 0);
    check("rst_ready", io_in_ready, 1);

    send(40'h1000, 0, 1, 0, 3, 40'h5000);
    check("call_valid", io_out_valid, 1);
    check("call_redirect", io_out_redirect, 0);
    check("call_target", io_out_target, 40'h5000);
    check("call_cfi", io_out_cfi_type, 3);
    check("call_ptr", io_out_ptr, 0);
    send(40'h5000, 0, 0, 1, 3, 40'h0);
    check("ret_redirect", io_out_redirect, 1);
    check("ret_target", io_out_target, 40'h1004);
    check("ret_ptr", io_out_ptr, 1);
    check("ret_count", io_out_count, 1);
    send(40'h0, 0, 0, 0, 0, 40'h0);
    check("after_ret_ptr", io_out_ptr, 0);
    check("after_ret_count", io_out_count, 0);
    @(posedge clock); #1;
    check("drain_valid", io_out_valid, 0);

    rst_dut();
    send(40'h800, 0, 0, 1, 3, 40'h1234);
    check("unf_redirect", io_out_redirect, 0);
    check("unf_target", io_out_target, 0);
    send(40'h0, 0, 0, 0, 0, 40'h0);
    check("unf_count", io_out_count, 0);
    check("unf_ptr", io_out_ptr, 0);
`ifdef RAS_PERF_CNT_EN
    check("unf_perf", io_perf_underflow, 1);
`endif
    send(40'h900, 0, 0, 0, 2, 40'h7777_0000);
    check("jal_redirect", io_out_redirect, 1);
    check("jal_target", io_out_target, 40'h7777_0000);

    rst_dut();
    for (int k = 1; k <= 33; k++) send(40'(k * 256), 0, 1, 0, 3, 40'h0);
    check("ovf_count", io_out_count, 32);
    check("ovf_ptr", io_out_ptr, 0);
    for (int k = 33; k >= 2; k--) begin
      send(40'h0, 0, 0, 1, 3, 40'h0);
      check("ovf_ret", io_out_target, 40'(k * 256 + 4));
      if (k == 33) begin
        check("ovf_ret_count", io_out_count, 32);
        check("ovf_ret_ptr", io_out_ptr, 1);
      end
    end
    send(40'h0, 0, 0, 1, 3, 40'h0);
    check("ovf_empty_redirect", io_out_redirect, 0);
    check("ovf_empty_count", io_out_count, 0);
    check("ovf_empty_ptr", io_out_ptr, 1);
`ifdef RAS_PERF_CNT_EN
    check("ovf_perf", io_perf_overflow, 1);
`endif

    rst_dut();
    io_out_ready = 1'b0;
    io_in_pc = 40'h4000; io_in_rvc = 0; io_in_is_call = 1; io_in_is_ret = 0;
    io_in_cfi_type = 3; io_in_target = 40'h9000; io_in_valid = 1'b1;
    @(posedge clock); #1;
    check("bp_valid", io_out_valid, 1);
    check("bp_ready", io_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp_hold_ready", io_in_ready, 0);
      check("bp_hold_target", io_out_target, 40'h9000);
      check("bp_hold_valid", io_out_valid, 1);
    end
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp_drain", io_out_valid, 0);
    send(40'h0, 0, 0, 1, 3, 40'h0);
    check("bp_ret_target", io_out_target, 40'h4004);
    check("bp_ret_count", io_out_count, 1);

    rst_dut();
    send(40'h10, 0, 1, 0, 3, 40'h0);
    send(40'h20, 0, 1, 0, 3, 40'h0);
    check("rs_ckpt_ptr", io_out_ptr, 1);
    check("rs_ckpt_count", io_out_count, 1);
    send(40'h30, 0, 1, 0, 3, 40'h0);
    io_out_ready = 1'b0;
    io_restore_valid = 1'b1; io_restore_ptr = 5'd1; io_restore_count = 6'd1;
    #1;
    check("rs_ready", io_in_ready, 0);
    @(posedge clock); #1;
    io_restore_valid = 1'b0;
    io_out_ready = 1'b1;
    check("rs_valid", io_out_valid, 0);
    send(40'h0, 0, 0, 1, 3, 40'h0);
    check("rs_ret_target", io_out_target, 40'h14);
    check("rs_ret_redirect", io_out_redirect, 1);
    check("rs_ret_ptr", io_out_ptr, 1);
    io_restore_valid = 1'b1; io_restore_ptr = 5'd3; io_restore_count = 6'd40;
    @(posedge clock); #1;
    io_restore_valid = 1'b0;
    send(40'h0, 0, 0, 1, 3, 40'h0);
    check("rs_clamp_count", io_out_count, 32);
    check("rs_clamp_target", io_out_target, 40'h34);

    rst_dut();
    send(40'h2000, 1, 1, 0, 3, 40'h0);
    send(40'h3000, 0, 1, 1, 3, 40'h0);
    check("co_target", io_out_target, 40'h2002);
    check("co_redirect", io_out_redirect, 1);
    check("co_count", io_out_count, 1);
    send(40'h0, 0, 0, 1, 3, 40'h0);
    check("co_top", io_out_target, 40'h3004);
    check("co_after_count", io_out_count, 1);
    check("co_after_ptr", io_out_ptr, 1);

    rst_dut();
    io_out_ready = 1'b0;
    send(40'h0, 0, 0, 0, 2, 40'hAAA0);
    check("fl_load", io_out_target, 40'hAAA0);
    io_flush = 1'b1;
    @(posedge clock); #1;
    check("fl_kill", io_out_valid, 0);
    send(40'h0, 0, 0, 0, 2, 40'hBBB0);
    io_flush = 1'b0;
    check("fl_accept_valid", io_out_valid, 1);
    check("fl_accept_target", io_out_target, 40'hBBB0);
    io_out_ready = 1'b1;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
